cpu_lsu: RTL
============

Name: cpu_lsu

Overview:
CPU-side load/store initiator that drives the cpu_dcache request interface and consumes its read-return channel. It accepts one memory micro-op per cycle from the execute stage. Stores become byte-laned write requests; loads become tagged read requests. Returned read data is aligned, sign/zero-extended and presented to the register-file writeback port. Returns are in-order, and a small internal FIFO holds per-load format information between issue and return.

Parameters:
MAX_OUTSTANDING, 4, maximum loads in flight; power of two, 2..16.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
lsu_in_valid  input  1  execute stage presents a memory op
lsu_in_ready  output  1  op accepted this cycle when valid&&ready
lsu_in_op  input  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
lsu_in_addr  input  32  byte address
lsu_in_data  input  32  store data (low bits significant)
lsu_in_rd  input  5  load destination register
cpu_dcache_request  output  1  request valid
cpu_dcache_ready  input  1  dcache accepts request this cycle
cpu_dcache_write  output  1  1 = store
cpu_dcache_address  output  32  byte address
cpu_dcache_burst  output  1  tied 0
cpu_dcache_wstrb  output  4  byte enables (stores); 0 for loads
cpu_dcache_wdata  output  32  store data; for loads {23'b0, tag}
cpu_dcache_rvalid  input  1  read data returned
cpu_dcache_rdata  input  32  read data
cpu_dcache_rtag  input  9  echo of load tag
wb_valid  output  1  writeback strobe, one cycle
wb_rd  output  5  writeback register
wb_data  output  32  extended load result
exc_valid  output  1  misaligned-access pulse
exc_addr  output  32  faulting address
lsu_busy  output  1  request pending or loads outstanding

Behaviour:
- Reset: every output and all internal state go to 0. This includes the request register, FIFO pointers/count, wb_*, exc_* and lsu_busy. Any loads in flight are forgotten, and returns arriving after reset is released are discarded.
- Request register: a single output stage that holds its contents while request && !ready.
- lsu_in_ready = (!request || cpu_dcache_ready) && (op is store || load_count < MAX_OUTSTANDING). There is no bypass of a same-cycle return.
- Accepted op → request register loads on the next clock edge. Issue latency is 1 cycle.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Op is accepted but no request is generated.
  - exc_valid=1 and exc_addr=addr for exactly one cycle, in the cycle after acceptance.
- Stores:
  - SB: wdata = data[7:0] replicated ×4; wstrb = 1<<addr[1:0].
  - SH: wdata = data[15:0] replicated ×2; wstrb = 0011 if addr[1]=0, else 1100.
  - SW: wdata = data; wstrb = 1111.
  - Address is passed unmodified.
- Loads:
  - tag[4:0] = rd; tag[8:5] = FIFO write slot index (zero-extended).
  - On acceptance, push {addr[1:0], op} to the info FIFO and increment load_count.
- Return: on rvalid, pop the FIFO head.
  - Shift rdata right by 8*offset.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Next cycle: wb_valid=1, wb_rd=rtag[4:0], wb_data=result. Writeback latency is 1 cycle from rvalid.
  - rd=0 loads still produce wb_valid.
- Simultaneous push and pop: load_count is unchanged and pointers wrap modulo MAX_OUTSTANDING.
- rvalid with an empty FIFO: ignored, no writeback.
- lsu_busy = request || load_count≠0.

Optional Feature:
LSU_TAG_CHECK_EN: when defined, adds an output port tag_err (1 bit, reset 0). tag_err is a one-cycle pulse, coincident with wb_valid timing, whenever rtag[8:5] ≠ FIFO read index or rvalid arrives with the FIFO empty. Writeback still proceeds normally in the mismatch case. When not defined, tag_err does not exist and rtag[8:5] is ignored.

Test Plan:
- SB addr 0x1003 data 0x000000A5, ready=1 → next cycle request=1, write=1, wstrb=1000, wdata=0xA5A5A5A5, address=0x1003.
- LB rd=7 addr 0x2001, rdata=0x1234F0CC returned with rtag=0x007 → wb_valid, wb_rd=7, wb_data=0xFFFFFFF0. Same case with LBU → 0x000000F0.
- LH addr 0x3001 → no request, exc_valid=1, exc_addr=0x00003001 for one cycle; the next op is accepted normally.
- Stall: ready=0 for 3 cycles while SW 0x4000/0xDEADBEEF is pending → request, address and wdata held stable; lsu_in_ready=0 until the cycle ready=1.
- 4 back-to-back loads with rvalid withheld → 5th load sees lsu_in_ready=0. After one return, ready rises the following cycle. Slot indices are 0,1,2,3 then 0 (wrap).
- Assert reset with 2 loads outstanding, then deliver 2 rvalids after release → no wb_valid; lsu_busy=0.

Source files
------------

// File: rtl/cpu_lsu.sv
// cpu_lsu -- CPU-side load/store initiator for the cpu_dcache request port.
//
// Accepts one memory micro-op per cycle from execute. Stores become byte-laned
// write requests. Loads become tagged read requests, with the tag carried in
// wdata[8:0]. A small in-order FIFO keeps {offset, op} for each load in flight.
// When a read returns, this format is used to align and extend the data before
// it goes to the register-file writeback port.
//
// Optional build macro:
//   LSU_TAG_CHECK_EN - adds output tag_err. It pulses with writeback timing when
//                      rtag[8:5] does not match the FIFO read slot, or when a
//                      return arrives with no load outstanding.
//
// Ports:
//   clock, reset             - clock; asynchronous active-low reset
//   lsu_in_*                 - execute-stage op (valid/ready, op, addr, data, rd)
//   cpu_dcache_request/ready - request handshake
//   cpu_dcache_write/address/burst/wstrb/wdata - request payload
//   cpu_dcache_rvalid/rdata/rtag - in-order read-return channel
//   wb_valid/wb_rd/wb_data   - one-cycle load writeback
//   exc_valid/exc_addr       - misaligned-access pulse and faulting address
//   lsu_busy                 - request pending or loads outstanding
//   tag_err                  - (LSU_TAG_CHECK_EN only) return-tag mismatch pulse
module cpu_lsu #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_in_valid,
  output logic        lsu_in_ready,
  input  logic [2:0]  lsu_in_op,
  input  logic [31:0] lsu_in_addr,
  input  logic [31:0] lsu_in_data,
  input  logic [4:0]  lsu_in_rd,
  output logic        cpu_dcache_request,
  input  logic        cpu_dcache_ready,
  output logic        cpu_dcache_write,
  output logic [31:0] cpu_dcache_address,
  output logic        cpu_dcache_burst,
  output logic [3:0]  cpu_dcache_wstrb,
  output logic [31:0] cpu_dcache_wdata,
  input  logic        cpu_dcache_rvalid,
  input  logic [31:0] cpu_dcache_rdata,
  input  logic [8:0]  cpu_dcache_rtag,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [31:0] exc_addr,
  output logic        lsu_busy
`ifdef LSU_TAG_CHECK_EN
  ,
  output logic        tag_err
`endif
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  // Align returned data by the byte offset, then sign- or zero-extend it per op.
  function automatic logic [31:0] format_load(input logic [2:0] op,
                                              input logic [1:0] off,
                                              input logic [31:0] data);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = data >> {off, 3'b000};
    result  = shifted;
    case (op)
      OP_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      OP_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      OP_LBU:  result = {24'd0, shifted[7:0]};
      OP_LHU:  result = {16'd0, shifted[15:0]};
      OP_LW:   result = shifted;
      default: result = shifted;
    endcase
    return result;
  endfunction

  // Request output stage
  logic        req_valid_r;
  logic        req_write_r;
  logic [31:0] req_addr_r;
  logic [3:0]  req_wstrb_r;
  logic [31:0] req_wdata_r;

  // Load-format FIFO: entry = {addr[1:0], op}
  logic [4:0]       info_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic        wb_valid_r;
  logic [4:0]  wb_rd_r;
  logic [31:0] wb_data_r;
  logic        exc_valid_r;
  logic [31:0] exc_addr_r;

  logic        is_store_s;
  logic        misaligned_s;
  logic [3:0]  store_wstrb_s;
  logic [31:0] store_wdata_s;
  logic [8:0]  load_tag_s;
  logic [31:0] load_wdata_s;
  logic        room_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic [4:0]  head_s;
  logic [31:0] load_result_s;

  // Decode the incoming op: store/load class, alignment and store lane layout.
  always_comb begin
    is_store_s    = 1'b0;
    misaligned_s  = 1'b0;
    store_wstrb_s = 4'b0000;
    store_wdata_s = 32'd0;
    case (lsu_in_op)
      OP_LB, OP_LBU: begin
        misaligned_s = 1'b0;
      end
      OP_LH, OP_LHU: begin
        misaligned_s = lsu_in_addr[0];
      end
      OP_LW: begin
        misaligned_s = (lsu_in_addr[1:0] != 2'b00);
      end
      OP_SB: begin
        is_store_s    = 1'b1;
        store_wstrb_s = 4'b0001 << lsu_in_addr[1:0];
        store_wdata_s = {4{lsu_in_data[7:0]}};
      end
      OP_SH: begin
        is_store_s    = 1'b1;
        misaligned_s  = lsu_in_addr[0];
        store_wdata_s = {2{lsu_in_data[15:0]}};
        if (lsu_in_addr[1]) begin
          store_wstrb_s = 4'b1100;
        end else begin
          store_wstrb_s = 4'b0011;
        end
      end
      OP_SW: begin
        is_store_s    = 1'b1;
        misaligned_s  = (lsu_in_addr[1:0] != 2'b00);
        store_wstrb_s = 4'b1111;
        store_wdata_s = lsu_in_data;
      end
      default: begin
        is_store_s    = 1'b0;
        misaligned_s  = 1'b0;
        store_wstrb_s = 4'b0000;
        store_wdata_s = 32'd0;
      end
    endcase
  end

  // The tag names the FIFO slot this load will occupy, plus its destination register.
  assign load_tag_s   = {4'(wr_ptr_r), lsu_in_rd};
  assign load_wdata_s = {23'd0, load_tag_s};

  // Stores never need a FIFO slot. A load needs a free slot, even a misaligned one.
  assign room_s       = (count_r < CNT_MAX);
  assign lsu_in_ready = (!req_valid_r || cpu_dcache_ready) && (is_store_s || room_s);
  assign accept_s     = lsu_in_valid && lsu_in_ready;
  assign push_s       = accept_s && !is_store_s && !misaligned_s;
  // A return with nothing outstanding (for example, in flight across reset) is dropped.
  assign pop_s        = cpu_dcache_rvalid && (count_r != CNT_ZERO);

  assign head_s        = info_mem_r[rd_ptr_r];
  assign load_result_s = format_load(head_s[2:0], head_s[4:3], cpu_dcache_rdata);

  // Request register: load on accept. Drop it once the dcache has taken it. Hold while stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_valid_r <= 1'b0;
      req_write_r <= 1'b0;
      req_addr_r  <= 32'd0;
      req_wstrb_r <= 4'b0000;
      req_wdata_r <= 32'd0;
    end else if (accept_s) begin
      req_valid_r <= !misaligned_s;
      req_write_r <= is_store_s;
      req_addr_r  <= lsu_in_addr;
      req_wstrb_r <= is_store_s ? store_wstrb_s : 4'b0000;
      req_wdata_r <= is_store_s ? store_wdata_s : load_wdata_s;
    end else if (cpu_dcache_ready) begin
      req_valid_r <= 1'b0;
    end
  end

  // Format FIFO storage: written at the write slot when an aligned load is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        info_mem_r[i] <= 5'd0;
      end
    end else if (push_s) begin
      info_mem_r[wr_ptr_r] <= {lsu_in_addr[1:0], lsu_in_op};
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Writeback stage: one cycle after a return is popped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= 32'd0;
    end else begin
      wb_valid_r <= pop_s;
      if (pop_s) begin
        wb_rd_r   <= cpu_dcache_rtag[4:0];
        wb_data_r <= load_result_s;
      end
    end
  end

  // Misalignment pulse: the cycle after a misaligned op is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exc_valid_r <= 1'b0;
      exc_addr_r  <= 32'd0;
    end else begin
      exc_valid_r <= accept_s && misaligned_s;
      exc_addr_r  <= (accept_s && misaligned_s) ? lsu_in_addr : 32'd0;
    end
  end

`ifdef LSU_TAG_CHECK_EN
  // Tag check: flag a return whose slot disagrees with the FIFO head, or one that arrives with nothing outstanding.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_err <= 1'b0;
    end else begin
      tag_err <= cpu_dcache_rvalid &&
                 ((count_r == CNT_ZERO) || (cpu_dcache_rtag[8:5] != 4'(rd_ptr_r)));
    end
  end
`else
  // Slot bits of the returned tag are informational only in this build.
  logic unused_rtag_s;
  assign unused_rtag_s = ^cpu_dcache_rtag[8:5];
`endif

  assign cpu_dcache_request = req_valid_r;
  assign cpu_dcache_write   = req_write_r;
  assign cpu_dcache_address = req_addr_r;
  assign cpu_dcache_burst   = 1'b0;
  assign cpu_dcache_wstrb   = req_wstrb_r;
  assign cpu_dcache_wdata   = req_wdata_r;
  assign wb_valid           = wb_valid_r;
  assign wb_rd              = wb_rd_r;
  assign wb_data            = wb_data_r;
  assign exc_valid          = exc_valid_r;
  assign exc_addr           = exc_addr_r;
  assign lsu_busy           = req_valid_r || (count_r != CNT_ZERO);

endmodule
